// File: rtl/roce_drop_pkg.sv
`default_nettype none
// ============================================================================
// Module      : roce_drop_pkg
// Description : Shared encodings for the RoCE TX drop scheduler: decision
//               modes, frame-tracking FSM states, the LFSR feedback
//               polynomial and the LFSR step function.
// Revision    : 1.0 - initial release
// ============================================================================
package roce_drop_pkg;

  // Decision mode encodings carried on cfg_mode; 2'd3 is reserved (acts as OFF)
  localparam logic [1:0] C_MODE_OFF      = 2'd0;
  localparam logic [1:0] C_MODE_RANDOM   = 2'd1;
  localparam logic [1:0] C_MODE_PERIODIC = 2'd2;

  // Frame tracking states
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_FRAME      = 2'd1,
    ST_FRAME_PEND = 2'd2
  } state_e;

  // Galois feedback taps (right-shifting form)
  localparam logic [31:0] C_LFSR_POLY = 32'h80200003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? C_LFSR_POLY : 32'h0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/roce_lfsr32.sv
`default_nettype none
// ============================================================================
// Module      : roce_lfsr32
// Description : 32-bit Galois LFSR that steps once per cycle in which
//               'advance' is high. 'value' is the current (pre-step) state.
// Ports       : clk     - clock
//               rst     - asynchronous active-low reset (loads SEED)
//               advance - step the register this cycle
//               value   - current LFSR contents
// Revision    : 1.0 - initial release
// ============================================================================
module roce_lfsr32
  import roce_drop_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE12468
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  output logic [31:0] value
);

  logic [31:0] r_value;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_value <= SEED;
    end else if (advance) begin
      r_value <= lfsr_step(r_value);
    end
  end

  assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/roce_drop_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : roce_drop_scheduler
// Description : Per-frame drop decision for the RoCE TX loss-injection path.
//               Monitors BTH and payload handshakes, makes one decision per
//               accepted header (one-shot arm, seeded LFSR or periodic
//               counter) and holds it on drop_packet for the frame lifetime.
//               Up to one header accepted before the current frame's tlast
//               is queued; a further early header flags err_overrun.
// Build macro : ROCE_DROP_STATS_EN - when defined, frame_count, drop_count,
//               err_overrun and cnt_clear are implemented; otherwise the
//               statistics outputs are tied to 0 and cnt_clear is ignored.
// Ports       : clk, rst (async active-low)
//               cfg_enable, cfg_mode, cfg_threshold, cfg_period, cfg_oneshot
//               cnt_clear
//               bth_valid/bth_ready, pl_tvalid/pl_tready/pl_tlast (monitor)
//               drop_packet, in_frame, oneshot_armed
//               frame_count, drop_count, err_overrun
// Revision    : 1.0 - initial release
// ============================================================================
module roce_drop_scheduler
  import roce_drop_pkg::*;
#(
  parameter logic [31:0] LFSR_SEED = 32'hACE12468,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_enable,
  input  logic [1:0]           cfg_mode,
  input  logic [31:0]          cfg_threshold,
  input  logic [15:0]          cfg_period,
  input  logic                 cfg_oneshot,
  input  logic                 cnt_clear,
  input  logic                 bth_valid,
  input  logic                 bth_ready,
  input  logic                 pl_tvalid,
  input  logic                 pl_tready,
  input  logic                 pl_tlast,
  output logic                 drop_packet,
  output logic                 in_frame,
  output logic                 oneshot_armed,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic [CNT_WIDTH-1:0] drop_count,
  output logic                 err_overrun
);

  logic        w_hs_bth;
  logic        w_hs_last;
  logic        w_overrun;
  logic        w_decision;
  logic [31:0] w_lfsr;
  logic [15:0] w_pcnt_next;

  state_e      r_state;
  logic        r_cur;       // decision of the frame on the wire (0 when idle)
  logic        r_pend;      // decision of a header accepted before tlast
  logic        r_in_frame;
  logic        r_armed;
  logic [15:0] r_pcnt;

  assign w_hs_bth  = bth_valid & bth_ready;
  assign w_hs_last = pl_tvalid & pl_tready & pl_tlast;

  // A third header while one decision is already queued has nowhere to go
  assign w_overrun = (r_state == ST_FRAME_PEND) & w_hs_bth & ~w_hs_last;

  roce_lfsr32 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (w_hs_bth),
    .value   (w_lfsr)
  );

  // Decision for a header accepted this cycle. The periodic counter only
  // runs while periodic mode is live; period 0 never matches so it free-runs.
  always_comb begin
    w_decision  = 1'b0;
    w_pcnt_next = r_pcnt;
    if (cfg_enable && (cfg_mode == C_MODE_PERIODIC)) begin
      if ((cfg_period != 16'd0) && (r_pcnt == cfg_period - 16'd1)) begin
        w_pcnt_next = 16'd0;
      end else begin
        w_pcnt_next = r_pcnt + 16'd1;
      end
    end
    if (r_armed) begin
      w_decision = 1'b1;
    end else if (cfg_enable) begin
      case (cfg_mode)
        C_MODE_RANDOM:   w_decision = (w_lfsr < cfg_threshold);
        C_MODE_PERIODIC: w_decision = (cfg_period != 16'd0) &&
                                      (r_pcnt == cfg_period - 16'd1);
        default:         w_decision = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cur      <= 1'b0;
      r_pend     <= 1'b0;
      r_in_frame <= 1'b0;
      r_armed    <= 1'b0;
      r_pcnt     <= 16'd0;
    end else begin
      // A header consumes the arm; a pulse in the same cycle re-arms for
      // the following frame.
      if (w_hs_bth) begin
        r_armed <= cfg_oneshot;
        r_pcnt  <= w_pcnt_next;
      end else if (cfg_oneshot) begin
        r_armed <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_hs_bth) begin
            r_state    <= ST_FRAME;
            r_cur      <= w_decision;
            r_in_frame <= 1'b1;
          end
        end
        ST_FRAME: begin
          if (w_hs_bth && w_hs_last) begin
            r_cur <= w_decision;
          end else if (w_hs_bth) begin
            r_state <= ST_FRAME_PEND;
            r_pend  <= w_decision;
          end else if (w_hs_last) begin
            r_state    <= ST_IDLE;
            r_cur      <= 1'b0;
            r_in_frame <= 1'b0;
          end
        end
        ST_FRAME_PEND: begin
          // Header alone here is the overrun case: its decision is dropped
          if (w_hs_last) begin
            r_cur <= r_pend;
            if (w_hs_bth) begin
              r_pend <= w_decision;
            end else begin
              r_state <= ST_FRAME;
            end
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_cur      <= 1'b0;
          r_in_frame <= 1'b0;
        end
      endcase
    end
  end

  assign drop_packet   = r_cur;
  assign in_frame      = r_in_frame;
  assign oneshot_armed = r_armed;

`ifdef ROCE_DROP_STATS_EN
  logic [CNT_WIDTH-1:0] r_frame_count;
  logic [CNT_WIDTH-1:0] r_drop_count;
  logic                 r_err_overrun;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_count <= '0;
      r_drop_count  <= '0;
      r_err_overrun <= 1'b0;
    end else if (cnt_clear) begin
      r_frame_count <= '0;
      r_drop_count  <= '0;
      r_err_overrun <= 1'b0;
    end else begin
      if (w_hs_bth && (r_frame_count != {CNT_WIDTH{1'b1}})) begin
        r_frame_count <= r_frame_count + CNT_WIDTH'(1);
      end
      // Discarded overrun decisions are still counted
      if (w_hs_bth && w_decision && (r_drop_count != {CNT_WIDTH{1'b1}})) begin
        r_drop_count <= r_drop_count + CNT_WIDTH'(1);
      end
      if (w_overrun) begin
        r_err_overrun <= 1'b1;
      end
    end
  end

  assign frame_count = r_frame_count;
  assign drop_count  = r_drop_count;
  assign err_overrun = r_err_overrun;
`else
  logic w_unused;
  assign w_unused    = ^{cnt_clear, w_overrun};
  assign frame_count = '0;
  assign drop_count  = '0;
  assign err_overrun = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/roce_drop_scheduler.md
# roce_drop_scheduler

Per-frame drop-decision controller for the RoCE TX loss-injection path. It watches the BTH and payload handshakes between the RoCE TX source and the packet dropper, and decides once per frame whether that frame is corrupted. The decision comes from a seeded LFSR, a periodic counter or a one-shot arm. It holds a registered `drop_packet` level for the frame's lifetime, which the dropper ORs into `tuser` on the `tlast` beat, and it keeps frame and drop statistics.

## Interface
- `LFSR_SEED`, default 32'hACE12468: LFSR reset value; must be nonzero.
- `CNT_WIDTH`, default 32: width of the statistics counters.
- `clk`  in  1  single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `cfg_enable`  in  1  enables random and periodic decisions.
- `cfg_mode`  in  2  decision mode: 0 OFF, 1 RANDOM, 2 PERIODIC; 3 is reserved and behaves as OFF.
- `cfg_threshold`  in  32  RANDOM mode drops when lfsr < threshold (unsigned).
- `cfg_period`  in  16  PERIODIC mode drops every Nth frame; 0 means never drop.
- `cfg_oneshot`  in  1  single-cycle pulse that arms a drop of the next frame.
- `cnt_clear`  in  1  pulse that zeroes the counters and the error flag.
- `bth_valid`, `bth_ready`  in  1 each  monitored BTH handshake.
- `pl_tvalid`, `pl_tready`, `pl_tlast`  in  1 each  monitored payload handshake.
- `drop_packet`  out  1  drop decision for the frame in flight.
- `in_frame`  out  1  high from BTH acceptance until that frame's `tlast`.
- `oneshot_armed`  out  1  a one-shot drop is pending.
- `frame_count`, `drop_count`  out  CNT_WIDTH each  saturating statistics counters.
- `err_overrun`  out  1  sticky: a header arrived while a pending decision was already held.

## Operation
- `hs_bth` = `bth_valid & bth_ready`; `hs_last` = `pl_tvalid & pl_tready & pl_tlast`.
- States:
  - IDLE: waiting for a header.
  - FRAME: current decision `cur` is held.
  - FRAME_PEND: current decision held, plus a one-deep `pend` decision for a header accepted early.
- Decision on `hs_bth`; all configuration inputs are sampled in that cycle.
  - One-shot armed: decision is 1 and the arm clears, regardless of `cfg_enable` or `cfg_mode`.
  - Otherwise, `cfg_enable` low: decision is 0.
  - RANDOM: decision is 1 when the current LFSR value < `cfg_threshold`.
  - PERIODIC: `pcnt` increments each frame; decision is 1 when `pcnt` == `cfg_period`-1, and `pcnt` then wraps to 0.
- LFSR: 32-bit Galois, polynomial 0x80200003. Advances exactly once per `hs_bth` in every mode, and the decision uses the pre-advance value.
- Transitions:
  - IDLE + `hs_bth` → FRAME.
  - FRAME + `hs_last` alone → IDLE.
  - FRAME + `hs_bth` + `hs_last` in the same cycle → stay in FRAME; `cur` takes the new decision.
  - FRAME + `hs_bth` alone → FRAME_PEND.
  - FRAME_PEND + `hs_last` → FRAME with `cur` ← `pend`.
  - FRAME_PEND + `hs_bth` → `err_overrun` sets and the new decision is discarded, but the LFSR and counters still update.
  - FRAME_PEND + `hs_bth` + `hs_last` in the same cycle → `cur` ← `pend`, `pend` ← new decision; stay in FRAME_PEND.
- `hs_last` in IDLE is ignored.
- Mode or threshold changes mid-frame do not affect latched decisions.
- A `cfg_oneshot` pulse while already armed has no effect.
- A `cfg_oneshot` pulse coinciding with `hs_bth` arms for the following frame. The current frame uses the prior arm state.
- Counters:
  - `frame_count` increments on every `hs_bth`.
  - `drop_count` increments on every decision of 1, including discarded ones.
  - Both saturate at all-ones.
  - `cnt_clear` has priority over a same-cycle increment.

## Timing
- Reset values:
  - `drop_packet`, `in_frame`, `oneshot_armed`, `err_overrun` = 0.
  - Counters = 0; `pcnt` = 0; LFSR = `LFSR_SEED`; state = IDLE.
- `drop_packet` and `in_frame` are registered: valid the cycle after `hs_bth`, and deasserted the cycle after the closing `hs_last`.
  - Upstream guarantees a frame's `tlast` beat never handshakes in the same cycle as its own BTH.
- `drop_packet` = `cur` while in FRAME or FRAME_PEND, else 0.
- Counters and flags update one cycle after the triggering event.
- Reset asserted mid-frame: immediate return to reset values. A frame in flight at reset release is not tracked.

## Configuration
- `ROCE_DROP_STATS_EN` defined: counters, `cnt_clear` and `err_overrun` are implemented.
- Not defined: `frame_count`, `drop_count` and `err_overrun` are tied to 0 and `cnt_clear` is ignored. The decision logic is identical in both builds.

## Structure
- Package `roce_drop_pkg` holds:
  - the mode encodings (OFF, RANDOM, PERIODIC);
  - the state encodings;
  - the LFSR polynomial constant 32'h80200003.
- Sub-module `roce_lfsr32`: seed parameter, `advance` input, 32-bit `value` output.

## Test plan
- `cfg_oneshot`, then 3 frames with `cfg_enable`=0 → only frame 1 has `drop_packet`=1; `drop_count`=1, `frame_count`=3.
- PERIODIC, `cfg_period`=4, 12 frames → frames 4, 8 and 12 dropped; `cfg_period`=0 → no drops.
- RANDOM with `cfg_threshold`=0 → 0 drops in 1000 frames. `cfg_threshold`=32'hFFFFFFFF → every frame dropped except where the LFSR equals all-ones. The drop sequence must match the reference model from `LFSR_SEED`.
- Back-to-back frames with `hs_bth` and `hs_last` in the same cycle → `drop_packet` switches to the new decision with no IDLE gap.
- Three headers before the first `tlast` → `err_overrun`=1, `frame_count`=3. After two `tlast`s the state is IDLE, and `cnt_clear` zeroes everything.
- Reset asserted mid-frame with `drop_packet`=1 → outputs return to 0 asynchronously, and the LFSR restarts at `LFSR_SEED`.
